rram_host_sequencer: RTL and testbench

RRAM_HOST_SEQUENCER -- requirements
Module: rram_host_sequencer

---
 rtl/rram_pkg.sv | 95 +++++++++
 rtl/seq_wait_counter.sv | 28 ++
 rtl/rram_host_sequencer.sv | 113 +++++++++++
 tb/tb_rram_host_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/rram_pkg.sv
// Shared definitions for the RRAM host sequencer: state and op encodings,
// command opcodes and the registered bus-output bundle.
package rram_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD1,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_CMD2,
    ST_WAIT_BUSY,
    ST_WAIT_READY,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    OP_FORM    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_READ    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  localparam logic [3:0] CMD_NONE    = 4'b0000;
  localparam logic [3:0] CMD_FORM_1  = 4'b0111;
  localparam logic [3:0] CMD_FORM_2  = 4'b0110;
  localparam logic [3:0] CMD_WRITE_1 = 4'b0001;
  localparam logic [3:0] CMD_WRITE_2 = 4'b0010;
  localparam logic [3:0] CMD_READ_1  = 4'b0011;
  localparam logic [3:0] CMD_READ_2  = 4'b0100;

  // WAIT_BUSY gives the array this many cycles to pull RB low.
  localparam int BUSY_CYCLES = 4;

  typedef struct packed {
    logic       ce;
    logic       cle;
    logic       ale;
    logic [3:0] command;
    logic [7:0] addr_out;
    logic       command_ready;
    logic       address_ready;
    logic       done;
    logic       err;
  } bus_t;

  function automatic logic [3:0] cmd_for(input op_e op, input logic second);
    logic [3:0] c;
    case (op)
      OP_FORM:  c = second ? CMD_FORM_2  : CMD_FORM_1;
      OP_WRITE: c = second ? CMD_WRITE_2 : CMD_WRITE_1;
      OP_READ:  c = second ? CMD_READ_2  : CMD_READ_1;
      default:  c = CMD_NONE;
    endcase
    return c;
  endfunction

  // Bus levels seen while the FSM sits in state s.
  function automatic bus_t bus_for(input state_e s, input op_e op, input logic [15:0] addr);
    bus_t b;
    b    = '0;
    b.ce = 1'b1;
    case (s)
      ST_CMD1: begin
        b.ce            = 1'b0;
        b.cle           = 1'b1;
        b.command       = cmd_for(op, 1'b0);
        b.command_ready = 1'b1;
      end
      ST_ADDR_HI: begin
        b.ce       = 1'b0;
        b.ale      = 1'b1;
        b.addr_out = addr[15:8];
      end
      ST_ADDR_LO: begin
        b.ce            = 1'b0;
        b.ale           = 1'b1;
        b.addr_out      = addr[7:0];
        b.address_ready = 1'b1;
      end
      ST_CMD2: begin
        b.ce            = 1'b0;
        b.cle           = 1'b1;
        b.command       = cmd_for(op, 1'b1);
        b.command_ready = 1'b1;
      end
      ST_WAIT_BUSY, ST_WAIT_READY: b.ce = 1'b0;
      ST_DONE: b.done = 1'b1;
      ST_ERR:  b.err  = 1'b1;
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// 8-bit wait counter for the busy/ready phases; terminal flags the
// TIMEOUT-th wait cycle.
module seq_wait_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  output logic [7:0] count,
  output logic       terminal
);

  // NOTE: reset is sampled on the clock edge, so it lives inside the
  // always_ff branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign terminal = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/rram_host_sequencer.sv
// Host-side sequencer: turns form/write/read requests into the
// CMD1 / ADDR_HI / ADDR_LO / CMD2 bus sequence and tracks RB to completion.
module rram_host_sequencer
  import rram_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  input  logic        RB,
  output logic        CE,
  output logic        CLE,
  output logic        ALE,
  output logic [3:0]  command,
  output logic [7:0]  addr_out,
  output logic        command_ready,
  output logic        address_ready,
  output logic        done,
  output logic        err
);

  state_e      state, state_nx;
  op_e         op_q, op_nx;
  logic [15:0] addr_q, addr_nx;
  bus_t        bus_q;
  logic        cnt_clear, cnt_en, cnt_terminal;
  logic [7:0]  wait_count;

  seq_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .count    (wait_count),
    .terminal (cnt_terminal)
  );

  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx  = state;
    op_nx     = op_q;
    addr_nx   = addr_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (op_e'(req_op) == OP_ILLEGAL) begin
            state_nx = ST_ERR;
          end else begin
            state_nx = ST_CMD1;
            op_nx    = op_e'(req_op);
            addr_nx  = req_addr;
          end
        end
      end
      ST_CMD1:    state_nx = ST_ADDR_HI;
      ST_ADDR_HI: state_nx = ST_ADDR_LO;
      ST_ADDR_LO: state_nx = ST_CMD2;
      ST_CMD2: begin
        state_nx  = ST_WAIT_BUSY;
        cnt_clear = 1'b1;
      end
      ST_WAIT_BUSY: begin
        cnt_en = 1'b1;
        if (!RB || wait_count == 8'(BUSY_CYCLES - 1)) state_nx = ST_WAIT_READY;
      end
      ST_WAIT_READY: begin
        cnt_en = 1'b1;
        if (RB)                state_nx = ST_DONE;
        else if (cnt_terminal) state_nx = ST_ERR;
      end
      ST_DONE: state_nx = ST_IDLE;
      ST_ERR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the bus registers change
  // in the same edge as the state register.
  // NOTE: non-blocking assignments keep every register updating from
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_FORM;
      addr_q <= 16'h0000;
      bus_q  <= bus_for(ST_IDLE, OP_FORM, 16'h0000);
    end else begin
      state  <= state_nx;
      op_q   <= op_nx;
      addr_q <= addr_nx;
      bus_q  <= bus_for(state_nx, op_nx, addr_nx);
    end
  end

  assign req_ready     = (state == ST_IDLE);
  assign CE            = bus_q.ce;
  assign CLE           = bus_q.cle;
  assign ALE           = bus_q.ale;
  assign command       = bus_q.command;
  assign addr_out      = bus_q.addr_out;
  assign command_ready = bus_q.command_ready;
  assign address_ready = bus_q.address_ready;
  assign done          = bus_q.done;
  assign err           = bus_q.err;

endmodule

// File: tb/tb_rram_host_sequencer.sv
// Self-checking bench: per-transaction expected bus trace computed from
// the RB waveform, compared cycle by cycle.
module tb_rram_host_sequencer;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        RB;
  logic        CE, CLE, ALE;
  logic [3:0]  command;
  logic [7:0]  addr_out;
  logic        command_ready, address_ready, done, err;

  int checks = 0;
  int errors = 0;
  logic rb_seq [0:127];

  rram_host_sequencer #(.TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .RB            (RB),
    .CE            (CE),
    .CLE           (CLE),
    .ALE           (ALE),
    .command       (command),
    .addr_out      (addr_out),
    .command_ready (command_ready),
    .address_ready (address_ready),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  // {CE,CLE,ALE,command,addr_out,command_ready,address_ready,done,err,req_ready}
  function automatic logic [19:0] vec(input logic ce, input logic cle, input logic ale,
                                      input logic [3:0] cmd, input logic [7:0] ad,
                                      input logic cr, input logic ar, input logic dn,
                                      input logic er, input logic rr);
    return {ce, cle, ale, cmd, ad, cr, ar, dn, er, rr};
  endfunction

  function automatic logic [19:0] observed();
    return {CE, CLE, ALE, command, addr_out, command_ready, address_ready, done, err, req_ready};
  endfunction

  function automatic logic [3:0] spec_cmd(input logic [1:0] op, input bit second);
    case (op)
      2'b00:   return second ? 4'b0110 : 4'b0111;
      2'b01:   return second ? 4'b0010 : 4'b0001;
      2'b10:   return second ? 4'b0100 : 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RB is low for t in [lo_start, lo_start+lo_len), high elsewhere.
  task automatic set_rb(input int lo_start, input int lo_len);
    for (int t = 0; t < 128; t++) rb_seq[t] = !(t >= lo_start && t < lo_start + lo_len);
  endtask

  // Cycle t = 1 is the cycle after the accepting edge.
  task automatic run_txn(input string tag, input logic [1:0] op, input logic [15:0] addr);
    int busy_exit;
    int t_end;
    bit ok_done;
    logic [19:0] e;
    ok_done = 1'b0;
    if (op == 2'b11) begin
      t_end = 1;
    end else begin
      busy_exit = 8;
      for (int t = 5; t <= 8; t++) if (!rb_seq[t]) begin busy_exit = t; break; end
      t_end = 5 + TMO;
      for (int t = busy_exit + 1; t <= 4 + TMO; t++)
        if (rb_seq[t]) begin ok_done = 1'b1; t_end = t + 1; break; end
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    RB        = rb_seq[0];
    @(posedge clk); #1;
    for (int t = 1; t <= t_end + 1; t++) begin
      req_valid = (t <= t_end) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_op    = 2'($urandom);
      req_addr  = 16'($urandom);
      RB        = rb_seq[t];
      @(negedge clk);
      if (t == t_end + 1)  e = vec(1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 0, 1);
      else if (t == t_end) e = vec(1, 0, 0, 4'h0, 8'h00, 0, 0, ok_done, !ok_done, 0);
      else begin
        case (t)
          1:       e = vec(0, 1, 0, spec_cmd(op, 0), 8'h00, 1, 0, 0, 0, 0);
          2:       e = vec(0, 0, 1, 4'h0, addr[15:8], 0, 0, 0, 0, 0);
          3:       e = vec(0, 0, 1, 4'h0, addr[7:0], 0, 1, 0, 0, 0);
          4:       e = vec(0, 1, 0, spec_cmd(op, 1), 8'h00, 1, 0, 0, 0, 0);
          default: e = vec(0, 0, 0, 4'h0, 8'h00, 0, 0, 0, 0, 0);
        endcase
      end
      check($sformatf("%s_t%0d", tag, t), observed(), e);
      check($sformatf("%s_cle_ale_t%0d", tag, t), {19'd0, CLE & ALE}, 20'd0);
      if (t <= t_end) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 16'h0000;
    RB        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", observed(), vec(1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 0, 1));
    rst_n = 1'b1;

    set_rb(5, 3);
    run_txn("form_a55a", 2'b00, 16'hA55A);
    set_rb(0, 0);
    run_txn("read_0102", 2'b10, 16'h0102);
    set_rb(5, 200);
    run_txn("write_stuck", 2'b01, 16'hBEEF);
    set_rb(0, 0);
    run_txn("illegal", 2'b11, 16'h1234);
    set_rb(5, 1);
    run_txn("best_case", 2'b01, 16'h00FF);

    // Reset while in ADDR_HI abandons the sequence silently.
    set_rb(0, 0);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 16'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pre_addr_hi", observed(), vec(0, 0, 1, 4'h0, 8'h12, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_op", observed(), vec(1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 0, 1));
    @(negedge clk);
    check("rst_mid_op_quiet", observed(), vec(1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 0, 1));
    run_txn("after_rst", 2'b10, 16'h5AA5);

    for (int n = 0; n < 12; n++) begin
      set_rb(int'($urandom_range(5, 9)), int'($urandom_range(0, TMO + 3)));
      for (int t = 0; t < 5; t++) rb_seq[t] = 1'($urandom);
      run_txn($sformatf("rand%0d", n), 2'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
